// File: rtl/activation_stream_serializer_if.sv
// Matrix capture bus from the activation stage and the element stream toward writeback.
// master = surrounding environment, slave = serializer.
interface activation_stream_serializer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 16,
  parameter int IDX_W       = 5
);
  logic                              in_valid;
  logic [MATRIX_SIZE*DATA_WIDTH-1:0] in_data;
  logic [31:0]                       in_size;
  logic                              in_ready;
  logic                              out_valid;
  logic                              out_ready;
  logic signed [DATA_WIDTH-1:0]      out_data;
  logic [IDX_W-1:0]                  out_index;
  logic                              out_last;

  modport master (
    output in_valid, in_data, in_size, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data, in_size, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/activation_stream_serializer.sv
// Two-slot ping-pong buffer that captures whole activation matrices and streams
// them out element by element; matrices arriving while both slots are busy are dropped.
module activation_stream_serializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 16,
  parameter int IDX_W       = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  activation_stream_serializer_if.slave bus,
  output logic                          drop_pulse,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [15:0]                   matrix_count
);

  localparam int AW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  typedef logic signed [DATA_WIDTH-1:0] elem_t;

  elem_t            slot_data_q [2][MATRIX_SIZE];
  logic [IDX_W-1:0] slot_size_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic [IDX_W-1:0] rd_idx_q;
  logic             overflow_q;
  logic             drop_q;
  logic [15:0]      count_q;

  logic [IDX_W-1:0] eff_size;
  logic [IDX_W-1:0] head_size;
  logic             head_valid;
  logic             head_last;
  logic             hs;
  logic             pop;
  logic             want;
  logic             accept;
  logic             drop;

  always_comb begin
    if (bus.in_size > 32'(MATRIX_SIZE)) eff_size = IDX_W'(MATRIX_SIZE);
    else                                eff_size = bus.in_size[IDX_W-1:0];
  end

  assign head_valid = (occ_q != 2'd0);
  assign head_size  = slot_size_q[rd_ptr_q];
  assign head_last  = (rd_idx_q == head_size - IDX_W'(1));
  assign hs         = head_valid && bus.out_ready;
  assign pop        = hs && head_last;

  // A full buffer can still take a matrix when the head drains in the same cycle.
  assign want   = bus.in_valid && (bus.in_size != 32'd0);
  assign accept = want && ((occ_q != 2'd2) || pop);
  assign drop   = want && !accept;

  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_size_q[0] <= '0;
      slot_size_q[1] <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      occ_q          <= 2'd0;
      rd_idx_q       <= '0;
      overflow_q     <= 1'b0;
      drop_q         <= 1'b0;
      count_q        <= 16'd0;
    end else begin
      occ_q  <= occ_d;
      drop_q <= drop;
      if (accept) begin
        slot_size_q[wr_ptr_q] <= eff_size;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (hs) begin
        if (head_last) begin
          rd_idx_q <= '0;
          rd_ptr_q <= ~rd_ptr_q;
          count_q  <= count_q + 16'd1;
        end else begin
          rd_idx_q <= rd_idx_q + IDX_W'(1);
        end
      end
      if (drop)                overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

  // Element storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        slot_data_q[wr_ptr_q][i] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    bus.out_valid = head_valid;
    bus.out_data  = '0;
    bus.out_index = '0;
    bus.out_last  = 1'b0;
    if (head_valid) begin
      bus.out_data  = slot_data_q[rd_ptr_q][rd_idx_q[AW-1:0]];
      bus.out_index = rd_idx_q;
      bus.out_last  = head_last;
    end
  end

  assign bus.in_ready  = (occ_q != 2'd2);
  assign drop_pulse    = drop_q;
  assign overflow      = overflow_q;
  assign matrix_count  = count_q;

endmodule

// File: tb/tb_activation_stream_serializer.sv
// Self-checking bench: a queue-based reference model predicts the element stream,
// drops, overflow and matrix count; scenario tasks compare the DUT against it.
module tb_activation_stream_serializer;
  localparam int DW = 8;
  localparam int MS = 16;
  localparam int IW = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        drop_pulse;
  logic        overflow;
  logic [15:0] matrix_count;

  activation_stream_serializer_if #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .IDX_W(IW)) bus ();

  activation_stream_serializer #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .IDX_W(IW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .drop_pulse     (drop_pulse),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .matrix_count   (matrix_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] idx;
    logic          last;
  } elem_t;

  elem_t       pend_q[$];
  elem_t       exp_q[$];
  elem_t       act_q[$];
  int          nmat = 0;
  logic [15:0] m_count = 16'd0;
  bit          m_ovf = 1'b0;
  bit          m_drp = 1'b0;
  int          m_drops = 0;
  int          a_drops = 0;
  int          tests = 0;
  int          fails = 0;

  // Reference model, evaluated half a cycle before each rising edge.
  always @(negedge clk) begin : model
    elem_t e;
    bit    pop_last;
    bit    want;
    bit    acc;
    int    eff;
    if (!rst_n) begin
      pend_q.delete();
      nmat    = 0;
      m_count = 16'd0;
      m_ovf   = 1'b0;
      m_drp   = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) act_q.push_back('{bus.out_data, bus.out_index, bus.out_last});
      if (drop_pulse) a_drops++;
      pop_last = 1'b0;
      if (nmat > 0 && bus.out_ready) begin
        e = pend_q.pop_front();
        exp_q.push_back(e);
        pop_last = e.last;
      end
      want = bus.in_valid && (bus.in_size != 32'd0);
      acc  = want && (nmat < 2 || pop_last);
      if (pop_last) begin
        nmat--;
        m_count++;
      end
      if (acc) begin
        eff = (bus.in_size > MS) ? MS : int'(bus.in_size);
        for (int i = 0; i < eff; i++)
          pend_q.push_back('{bus.in_data[i*DW +: DW], IW'(i), (i == eff - 1)});
        nmat++;
      end
      m_drp = want && !acc;
      if (m_drp) begin
        m_drops++;
        m_ovf = 1'b1;
      end else if (clear_overflow) begin
        m_ovf = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MS*DW-1:0] rand_mat();
    logic [MS*DW-1:0] m;
    for (int i = 0; i < MS; i++) m[i*DW +: DW] = DW'($urandom);
    return m;
  endfunction

  task automatic send(input logic [31:0] size, input logic [MS*DW-1:0] data);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_size  = size;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    bus.out_ready = 1'b1;
    while ((nmat != 0 || bus.out_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL %s_drain_timeout: out_valid=%0b model_matrices=%0d, required drained within 300 cycles", name, bus.out_valid, nmat);
    end
    repeat (2) tick();
  endtask

  task automatic clear_logs();
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({bus.out_valid, bus.out_data, bus.out_index, bus.out_last} !== '0) begin
      fails++;
      $display("FAIL reset_out: got valid=%0b data=%0h idx=%0d last=%0b, required all 0",
               bus.out_valid, bus.out_data, bus.out_index, bus.out_last);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready);
    end
    tests++;
    if ({overflow, drop_pulse, matrix_count} !== '0) begin
      fails++;
      $display("FAIL reset_status: got ovf=%0b drop=%0b count=%0d, required 0",
               overflow, drop_pulse, matrix_count);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic test_single();
    logic [MS*DW-1:0] m;
    logic [DW-1:0]    vals [4];
    int               bad;
    vals = '{8'd5, 8'hFD, 8'h7F, 8'h80};
    m = '0;
    for (int i = 0; i < 4; i++) m[i*DW +: DW] = vals[i];
    bus.out_ready = 1'b1;
    send(32'd4, m);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 5'd0 || bus.out_data !== 8'sd5) begin
      fails++;
      $display("FAIL single_latency: got valid=%0b idx=%0d data=%0d, required 1/0/5",
               bus.out_valid, bus.out_index, bus.out_data);
    end
    drain("single");
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= act_q.size() || act_q[i] !== elem_t'{vals[i], IW'(i), (i == 3)}) bad++;
    tests++;
    if (bad != 0 || act_q.size() != 4) begin
      fails++;
      $display("FAIL single_stream: got %0d elems (%0d wrong), required 4 elems 5,-3,127,-128", act_q.size(), bad);
    end
    tests++;
    if (matrix_count !== 16'd1) begin
      fails++;
      $display("FAIL single_count: got %0d, required 1", matrix_count);
    end
    clear_logs();
  endtask

  task automatic test_backpressure();
    logic [DW+IW:0] prev;
    bit             prev_stall;
    int             unstable = 0;
    int             n = 0;
    int             bad = 0;
    logic [MS*DW-1:0] m;
    m = '0;
    m[0 +: 32] = {8'h80, 8'h7F, 8'hFD, 8'd5};
    bus.out_ready = 1'b1;
    send(32'd4, m);
    prev_stall = 1'b0;
    prev = '0;
    while ((bus.out_valid || nmat != 0) && n < 40) begin
      if (prev_stall && {bus.out_data, bus.out_index, bus.out_last} !== prev) unstable++;
      bus.out_ready = ~bus.out_ready;
      prev       = {bus.out_data, bus.out_index, bus.out_last};
      prev_stall = bus.out_valid && !bus.out_ready;
      tick();
      n++;
    end
    drain("backpressure");
    tests++;
    if (unstable != 0) begin
      fails++;
      $display("FAIL bp_stable: got %0d changes while stalled, required 0", unstable);
    end
    foreach (exp_q[i]) if (i >= act_q.size() || act_q[i] !== exp_q[i]) bad++;
    tests++;
    if (bad != 0 || act_q.size() != 4 || exp_q.size() != 4) begin
      fails++;
      $display("FAIL bp_stream: got %0d handshakes (%0d wrong), required 4", act_q.size(), bad);
    end
    tests++;
    if (matrix_count !== 16'd2) begin
      fails++;
      $display("FAIL bp_count: got %0d, required 2", matrix_count);
    end
    clear_logs();
  endtask

  task automatic test_overflow();
    int drops0 = a_drops;
    int bad = 0;
    bus.out_ready = 1'b0;
    send(32'd16, rand_mat());
    send(32'd16, rand_mat());
    send(32'd16, rand_mat());
    tests++;
    if (drop_pulse !== 1'b1 || overflow !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ovf_drop: got drop=%0b ovf=%0b in_ready=%0b, required 1/1/0", drop_pulse, overflow, bus.in_ready);
    end
    tick();
    tests++;
    if (drop_pulse !== 1'b0) begin
      fails++;
      $display("FAIL ovf_pulse_width: got drop=%0b one cycle later, required 0", drop_pulse);
    end
    clear_overflow = 1'b1;
    send(32'd16, rand_mat());
    clear_overflow = 1'b0;
    tests++;
    if (overflow !== 1'b1 || drop_pulse !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set_wins: got ovf=%0b drop=%0b, required 1/1", overflow, drop_pulse);
    end
    drain("overflow");
    tests++;
    if (a_drops - drops0 != 2 || m_drops < 2) begin
      fails++;
      $display("FAIL ovf_drop_count: got %0d drop pulses, required 2", a_drops - drops0);
    end
    foreach (exp_q[i]) if (i >= act_q.size() || act_q[i] !== exp_q[i]) bad++;
    tests++;
    if (bad != 0 || act_q.size() != 32 || exp_q.size() != 32) begin
      fails++;
      $display("FAIL ovf_stream: got %0d elems (%0d wrong), required 32", act_q.size(), bad);
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got %0b, required 0", overflow);
    end
    clear_logs();
  endtask

  task automatic test_edge_sizes();
    bus.out_ready = 1'b1;
    send(32'd0, rand_mat());
    repeat (3) tick();
    tests++;
    if (act_q.size() != 0 || overflow !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL size0: got %0d elems ovf=%0b valid=%0b, required 0/0/0", act_q.size(), overflow, bus.out_valid);
    end
    send(32'd40, rand_mat());
    drain("size40");
    tests++;
    if (act_q.size() != 16 || act_q[15].idx !== 5'd15 || act_q[15].last !== 1'b1 || act_q[14].last !== 1'b0) begin
      fails++;
      $display("FAIL size40: got %0d elems, required 16 with last only at index 15", act_q.size());
    end
    tests++;
    if (act_q != exp_q) begin
      fails++;
      $display("FAIL size40_data: got stream differing from model, required match");
    end
    clear_logs();
    send(32'd1, rand_mat());
    drain("size1");
    tests++;
    if (act_q.size() != 1 || act_q[0].idx !== 5'd0 || act_q[0].last !== 1'b1 || act_q[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL size1: got %0d elems, required 1 with idx 0 last 1", act_q.size());
    end
    clear_logs();
  endtask

  task automatic test_simultaneous();
    int drops0 = a_drops;
    int n = 0;
    int bad = 0;
    bus.out_ready = 1'b0;
    send(32'd3, rand_mat());
    send(32'd2, rand_mat());
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL simul_full: got in_ready=%0b, required 0", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    while (!(bus.out_valid && bus.out_last) && n < 10) begin
      tick();
      n++;
    end
    send(32'd2, rand_mat());
    tests++;
    if (drop_pulse !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_index !== 5'd0 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL simul_accept: got drop=%0b valid=%0b idx=%0d in_ready=%0b, required 0/1/0/0",
               drop_pulse, bus.out_valid, bus.out_index, bus.in_ready);
    end
    drain("simul");
    foreach (exp_q[i]) if (i >= act_q.size() || act_q[i] !== exp_q[i]) bad++;
    tests++;
    if (bad != 0 || act_q.size() != 7 || a_drops != drops0) begin
      fails++;
      $display("FAIL simul_stream: got %0d elems (%0d wrong) %0d drops, required 7 elems 0 drops",
               act_q.size(), bad, a_drops - drops0);
    end
    clear_logs();
  endtask

  task automatic test_reset_midstream();
    logic [MS*DW-1:0] m;
    int n = 0;
    bus.out_ready = 1'b1;
    send(32'd8, rand_mat());
    while (act_q.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || matrix_count !== 16'd0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid: got valid=%0b count=%0d in_ready=%0b, required 0/0/1", bus.out_valid, matrix_count, bus.in_ready);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    tick();
    m = '0;
    m[0 +: 16] = {8'd8, 8'd9};
    send(32'd2, m);
    drain("post_reset");
    tests++;
    if (act_q.size() != 2 || act_q[0] !== elem_t'{8'd9, 5'd0, 1'b0} || act_q[1] !== elem_t'{8'd8, 5'd1, 1'b1}) begin
      fails++;
      $display("FAIL rst_restart: got %0d elems, required 9@0 then 8@1 last", act_q.size());
    end
    clear_logs();
  endtask

  task automatic test_random();
    int bad = 0;
    int bad_cyc = 0;
    logic [31:0] sz;
    for (int c = 0; c < 2000; c++) begin
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      clear_overflow = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 4))
        0:       sz = 32'd0;
        1:       sz = 32'd1;
        2:       sz = $urandom_range(2, 16);
        3:       sz = $urandom_range(17, 40);
        default: sz = $urandom;
      endcase
      bus.in_size  = sz;
      bus.in_data  = rand_mat();
      bus.in_valid = ($urandom_range(0, 5) == 0);
      tick();
      if (overflow !== m_ovf || drop_pulse !== m_drp || bus.in_ready !== (nmat < 2) || matrix_count !== m_count)
        bad_cyc++;
    end
    bus.in_valid   = 1'b0;
    clear_overflow = 1'b0;
    tests++;
    if (bad_cyc != 0) begin
      fails++;
      $display("FAIL rand_status: got %0d cycles with ovf/drop/in_ready/count off model, required 0", bad_cyc);
    end
    drain("random");
    foreach (exp_q[i]) if (i >= act_q.size() || act_q[i] !== exp_q[i]) bad++;
    tests++;
    if (bad != 0 || act_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL rand_stream: got %0d elems (%0d wrong), required %0d", act_q.size(), bad, exp_q.size());
    end
    tests++;
    if (a_drops != m_drops || matrix_count !== m_count) begin
      fails++;
      $display("FAIL rand_totals: got drops=%0d count=%0d, required drops=%0d count=%0d",
               a_drops, matrix_count, m_drops, m_count);
    end
    clear_logs();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_size   = 32'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_edge_sizes();
    test_simultaneous();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/activation_stream_serializer.md
Name: activation_stream_serializer

Overview:
- Sits directly downstream of the activation-function stage.
- Captures each registered full-matrix result (data, element count and valid pulse) into a 2-slot ping-pong buffer.
- Streams the elements out one per cycle over a valid/ready interface, with element index and last flag, toward the output writeback/DMA path.
- Absorbs backpressure, because the activation stage has none; flags any dropped matrices.

Parameters:
DATA_WIDTH, 8, signed element width
MATRIX_SIZE, 16, max elements per matrix
IDX_W, 5, width of element index/size fields; must satisfy 2^IDX_W > MATRIX_SIZE

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  one-cycle pulse: matrix on in_data is valid
in_data  input  MATRIX_SIZE*DATA_WIDTH  flattened matrix; element i = in_data[i*DATA_WIDTH +: DATA_WIDTH]
in_size  input  32  active element count for this matrix
in_ready  output  1  at least one slot free (informational; upstream cannot stall)
out_valid  output  1  element available
out_ready  input  1  downstream accepts element
out_data  output  DATA_WIDTH  signed element
out_index  output  IDX_W  element index within matrix, 0-based
out_last  output  1  final element of current matrix
drop_pulse  output  1  one-cycle pulse: incoming matrix discarded, buffer full
overflow  output  1  sticky drop flag
clear_overflow  input  1  synchronous clear of overflow
matrix_count  output  16  matrices fully streamed; wraps at 65535->0

Behaviour:
- Reset (async, rst_n low): all slots invalid, occupancy=0, rd_idx=0, wr/rd slot pointers=0, overflow=0, drop_pulse=0, matrix_count=0.
- Outputs during reset: out_valid=0, out_data=0, out_index=0, out_last=0, in_ready=1.
- Reset mid-stream abandons buffered data; no partial output afterwards.
- Storage: 2 slots, each holding MATRIX_SIZE elements plus a size field.
- Slot write pointer and read pointer each toggle 0/1; occupancy counter takes values 0..2.
- Size capture:
  - eff_size = min(in_size, MATRIX_SIZE).
  - in_size==0: matrix ignored; no enqueue, no drop, no overflow.
- Accept rule on in_valid with eff_size>0:
  - Accept if occupancy<2, or occupancy==2 and the head matrix's final element handshakes in the same cycle.
  - Otherwise discard: drop_pulse=1 next cycle, overflow set.
- Latency: matrix accepted at edge N -> if the buffer was empty, out_valid=1 with out_index=0 from cycle N+1. Registered capture; no combinational in-to-out path.
- Output path:
  - out_valid = (occupancy>0).
  - out_data = head slot element[rd_idx]; out_index = rd_idx; out_last = (rd_idx == head size-1).
  - out_data/out_index/out_last held stable while out_valid && !out_ready.
  - When out_valid=0, out_data, out_index and out_last are driven 0.
- Handshake (out_valid && out_ready):
  - Not last: rd_idx+1.
  - Last: rd_idx=0, read pointer toggles, occupancy-1, matrix_count+1.
  - Back-to-back matrices stream with no bubble: next matrix index 0 in the cycle after the last.
- Simultaneous accept and pop: occupancy unchanged; both pointers advance.
- in_ready = (occupancy<2), combinational from registered state.
- overflow:
  - Set on any drop; cleared by clear_overflow.
  - Drop and clear in the same cycle: set wins.
- Element ordering: index 0 first; elements at index >= eff_size are never emitted.

Test Plan:
- Single matrix: in_size=4, elements {5,-3,127,-128}, out_ready=1 -> cycles N+1..N+4 emit 5,-3,127,-128, indices 0..3, out_last only on -128; matrix_count=1.
- Backpressure: same matrix, out_ready toggles 1,0,1,0... -> each element held stable while stalled; exactly 4 handshakes; no duplicates or skips.
- Overflow: out_ready=0, three in_valid pulses with in_size=16 -> first two accepted, third dropped, drop_pulse one cycle, overflow=1, in_ready=0. Release out_ready -> 32 elements out, then overflow cleared via clear_overflow.
- Edge sizes: in_size=0 -> no output, no overflow. in_size=40 -> exactly 16 elements, out_last at index 15. in_size=1 -> single element, out_last=1 at index 0.
- Simultaneous pop/accept: occupancy=2, out_ready=1 on head's last element while in_valid=1 -> new matrix accepted, no drop; next matrix starts at index 0 next cycle.
- Async reset mid-stream after 2 of 8 elements: out_valid=0 immediately; matrix_count=0. Post-reset matrix {9,8} streams correctly from index 0.
